fpu_itof_arbiter: RTL and testbench
===================================

// Module: fpu_itof_arbiter
// PURPOSE
// - Shares one pipelined int-to-float path (itof prenorm + normalizer, registered stages) among NUM_REQ requesters.
// - Round-robin grant, one operand accepted per cycle; issuing requester index carried alongside through the pipeline.
// - Drives shared-unit operand and stage enables; presents result + requester id on a valid/ready output with backpressure.
// - Sits between core/LSU int-to-float issue ports and the shared FPU conversion datapath.
// PARAMETERS
// - NUM_REQ    2   number of requesters, >=2
// - OP_WIDTH   32  integer operand width (C_FPU01_OP)
// - RES_WIDTH  32  float result width from normalizer
// - LATENCY    2   registered stages inside shared unit, >=1
// - ID_W       $clog2(NUM_REQ)  requester id width (derived, localparam)
// PORTS
// - Clk_CI          in   1                  clock, rising edge
// - Rst_RBI         in   1                  reset, asynchronous, active-low
// - Req_SI          in   NUM_REQ            per-requester request; operand valid while high
// - Operand_DI      in   NUM_REQ*OP_WIDTH   packed operands, requester i at [i*OP_WIDTH +: OP_WIDTH]
// - Gnt_SO          out  NUM_REQ            one-hot grant; operand accepted this cycle
// - Unit_Operand_DO out  OP_WIDTH           operand to shared unit stage 0 (mux of granted)
// - Unit_En_SO      out  1                  enable for all shared-unit stage registers
// - Unit_Result_DI  in   RES_WIDTH          shared-unit last-stage result
// - Valid_SO        out  1                  Result_DO/Id_DO valid
// - Ready_SI        in   1                  downstream accepts result
// - Result_DO       out  RES_WIDTH          converted float
// - Id_DO           out  ID_W               requester that issued Result_DO
// BEHAVIOUR
// - Reset (async, Rst_RBI=0): valid shift regs cleared, id regs 0, RR pointer 0; outputs Gnt_SO=0, Valid_SO=0, Id_DO=0, Unit_En_SO=1.
// - Stall_S = Valid_SO & ~Ready_SI. Unit_En_SO = ~Stall_S. On stall, valid/id regs and unit regs all hold; nothing is dropped.
// - Grant (combinational): when ~Stall_S, first i with Req_SI[i]=1 scanning from pointer upward, wrapping mod NUM_REQ.
//   Gnt_SO=0 when stalled or no request. Exactly one grant bit max.
// - Unit_Operand_DO = Operand_DI of granted requester; 0 when no grant.
// - Pipeline: Vld_S[0..LATENCY-1], Id_D[0..LATENCY-1] advance when Unit_En_SO=1.
//   Vld_S[0] <= |Gnt_SO, Id_D[0] <= granted index.
//   Bubbles (no grant) advance as invalid.
// - Output: Valid_SO = Vld_S[LATENCY-1], Id_DO = Id_D[LATENCY-1], Result_DO = Unit_Result_DI (pass-through).
// - Latency: grant in cycle N -> Valid_SO in cycle N+LATENCY if no stall; each stall cycle adds one.
// - Throughput: 1 result/cycle while Ready_SI=1. Full pipeline + stall -> no grants until Ready_SI.
// - RR pointer: on grant to i, pointer <= (i+1) mod NUM_REQ; unchanged on cycles without grant.
//   Guarantees no starvation; a held Req_SI is granted within NUM_REQ granting cycles.
// - Simultaneous Ready_SI=1 with new grant: output retires and new entry enters stage 0 the same cycle.
// - Requester must hold Req_SI and Operand_DI stable until granted; dropping Req_SI before grant withdraws it.
// - Reset mid-operation clears all in-flight entries; no result is produced for them.
// TESTING
// - Reset: assert Rst_RBI=0 asynchronously mid-cycle -> Gnt_SO=0, Valid_SO=0, Id_DO=0 immediately.
// - Single req: Req_SI=2'b01, Operand=32'd5, Ready=1 -> Gnt_SO=01 at N, Valid_SO=1, Id_DO=0 at N+2, Result from unit.
// - Contention: both requesters held 6 cycles, Ready=1 -> grants alternate 01,10,01,10,... and Id_DO sequence 0,1,0,1,...
// - Backpressure: pipeline full, Ready_SI=0 for 3 cycles -> Gnt_SO=0, Unit_En_SO=0, Valid/Id/Result held; then in-order resume.
// - Bubbles: Req pulses in cycles 0 and 3 only -> Valid_SO in cycles 2 and 5 only, no spurious valids.
// - Reset during flight: two entries in pipeline, pulse Rst_RBI=0 -> no Valid_SO after release until new grant+LATENCY.

Source files
------------

// File: rtl/fpu_itof_arbiter_if.sv
// Requester, shared-unit and result-port signals of the int-to-float arbiter.
interface fpu_itof_arbiter_if #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned OP_WIDTH  = 32,
  parameter int unsigned RES_WIDTH = 32
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          Req_SI;
  logic [NUM_REQ*OP_WIDTH-1:0] Operand_DI;
  logic [NUM_REQ-1:0]          Gnt_SO;
  logic [OP_WIDTH-1:0]         Unit_Operand_DO;
  logic                        Unit_En_SO;
  logic [RES_WIDTH-1:0]        Unit_Result_DI;
  logic                        Valid_SO;
  logic                        Ready_SI;
  logic [RES_WIDTH-1:0]        Result_DO;
  logic [ID_W-1:0]             Id_DO;

  modport master (
    input  Req_SI, Operand_DI, Unit_Result_DI, Ready_SI,
    output Gnt_SO, Unit_Operand_DO, Unit_En_SO, Valid_SO, Result_DO, Id_DO
  );

  modport slave (
    output Req_SI, Operand_DI, Unit_Result_DI, Ready_SI,
    input  Gnt_SO, Unit_Operand_DO, Unit_En_SO, Valid_SO, Result_DO, Id_DO
  );
endinterface

// File: rtl/fpu_itof_arbiter.sv
// Round-robin arbiter sharing one pipelined int-to-float unit among NUM_REQ
// requesters; tracks the issuing requester id alongside the unit's stages.
module fpu_itof_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned OP_WIDTH  = 32,
  parameter int unsigned RES_WIDTH = 32,
  parameter int unsigned LATENCY   = 2
) (
  input  logic               Clk_CI,
  input  logic               Rst_RBI,
  fpu_itof_arbiter_if.master bus
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_ptr_d;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               stall;
  logic [LATENCY-1:0] vld_q;
  logic [ID_W-1:0]    id_q [LATENCY];

  // A valid result the consumer refuses freezes the whole shared pipeline.
  assign stall              = vld_q[LATENCY-1] & ~bus.Ready_SI;
  assign bus.Unit_En_SO     = ~stall;
  assign bus.Valid_SO       = vld_q[LATENCY-1];
  assign bus.Id_DO          = id_q[LATENCY-1];
  assign bus.Result_DO      = bus.Unit_Result_DI;

  // Scan requests upward from the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin : grant_sel
    gnt_any             = 1'b0;
    gnt_idx             = '0;
    cand                = '0;
    rr_ptr_d            = rr_ptr_q;
    bus.Gnt_SO          = '0;
    bus.Unit_Operand_DO = '0;
    if (Rst_RBI && !stall) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
        if (!gnt_any && bus.Req_SI[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) begin
      bus.Gnt_SO[gnt_idx] = 1'b1;
      bus.Unit_Operand_DO = bus.Operand_DI[32'(gnt_idx)*OP_WIDTH +: OP_WIDTH];
      rr_ptr_d = (32'(gnt_idx) + 32'd1 == NUM_REQ) ? '0 : ID_W'(32'(gnt_idx) + 32'd1);
    end
  end

  // Valid/id shadow of the unit stages; bubbles shift through as invalid.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin : pipe_regs
    if (!Rst_RBI) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < int'(LATENCY); i++) id_q[i] <= '0;
    end else if (!stall) begin
      rr_ptr_q <= rr_ptr_d;
      vld_q[0] <= gnt_any;
      id_q[0]  <= gnt_idx;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_fpu_itof_arbiter.sv
// Directed table-driven bench for fpu_itof_arbiter with a two-stage unit model.
module tb_fpu_itof_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned OPW     = 32;
  localparam int unsigned RESW    = 32;
  localparam int unsigned LAT     = 2;
  localparam logic [31:0] BIAS    = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fpu_itof_arbiter_if #(.NUM_REQ(NUM_REQ), .OP_WIDTH(OPW), .RES_WIDTH(RESW)) bus ();

  fpu_itof_arbiter #(.NUM_REQ(NUM_REQ), .OP_WIDTH(OPW), .RES_WIDTH(RESW), .LATENCY(LAT)) dut (
    .Clk_CI (clk),
    .Rst_RBI(rst_n),
    .bus    (bus)
  );

  // Shared conversion unit stand-in: result = operand + BIAS, LAT stages deep.
  logic [31:0] u_s0, u_s1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_s0 <= '0;
      u_s1 <= '0;
    end else if (bus.Unit_En_SO) begin
      u_s0 <= bus.Unit_Operand_DO + BIAS;
      u_s1 <= u_s0;
    end
  end
  assign bus.Unit_Result_DI = u_s1;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] op0;
    logic [31:0] op1;
    logic        rdy;
    logic [1:0]  gnt;
    logic        en;
    logic [31:0] uop;
    logic        vld;
    logic        id;
    logic [31:0] res;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(logic [1:0] req, logic [31:0] op0, logic [31:0] op1, logic rdy,
                              logic [1:0] gnt, logic en, logic [31:0] uop, logic vld,
                              logic id, logic [31:0] res);
    vec_t v;
    v.req = req; v.op0 = op0; v.op1 = op1; v.rdy = rdy;
    v.gnt = gnt; v.en = en; v.uop = uop; v.vld = vld; v.id = id; v.res = res;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [31:0] op0, input logic [31:0] op1,
                       input logic rdy);
    @(posedge clk);
    #1;
    bus.Req_SI     = req;
    bus.Operand_DI = {op1, op0};
    bus.Ready_SI   = rdy;
  endtask

  initial begin
    tbl[0]  = mk(2'b01, 32'h5,   32'h0,   1, 2'b01, 1, 32'h5,   0, 0, 32'h0);
    tbl[1]  = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   0, 0, 32'h0);
    tbl[2]  = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   1, 0, 32'h1000_0005);
    tbl[3]  = mk(2'b11, 32'h100, 32'h200, 1, 2'b10, 1, 32'h200, 0, 0, 32'h0);
    tbl[4]  = mk(2'b11, 32'h100, 32'h200, 1, 2'b01, 1, 32'h100, 0, 0, 32'h0);
    tbl[5]  = mk(2'b11, 32'h100, 32'h200, 1, 2'b10, 1, 32'h200, 1, 1, 32'h1000_0200);
    tbl[6]  = mk(2'b11, 32'h100, 32'h200, 1, 2'b01, 1, 32'h100, 1, 0, 32'h1000_0100);
    tbl[7]  = mk(2'b11, 32'h100, 32'h200, 1, 2'b10, 1, 32'h200, 1, 1, 32'h1000_0200);
    tbl[8]  = mk(2'b11, 32'h100, 32'h200, 1, 2'b01, 1, 32'h100, 1, 0, 32'h1000_0100);
    tbl[9]  = mk(2'b11, 32'h100, 32'h200, 0, 2'b00, 0, 32'h0,   1, 1, 32'h1000_0200);
    tbl[10] = mk(2'b11, 32'h100, 32'h200, 0, 2'b00, 0, 32'h0,   1, 1, 32'h1000_0200);
    tbl[11] = mk(2'b11, 32'h100, 32'h200, 0, 2'b00, 0, 32'h0,   1, 1, 32'h1000_0200);
    tbl[12] = mk(2'b11, 32'h100, 32'h200, 1, 2'b10, 1, 32'h200, 1, 1, 32'h1000_0200);
    tbl[13] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   1, 0, 32'h1000_0100);
    tbl[14] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   1, 1, 32'h1000_0200);
    tbl[15] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   0, 0, 32'h0);
    tbl[16] = mk(2'b01, 32'h33,  32'h0,   1, 2'b01, 1, 32'h33,  0, 0, 32'h0);
    tbl[17] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   0, 0, 32'h0);
    tbl[18] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   1, 0, 32'h1000_0033);
    tbl[19] = mk(2'b10, 32'h0,   32'h44,  1, 2'b10, 1, 32'h44,  0, 0, 32'h0);
    tbl[20] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   0, 0, 32'h0);
    tbl[21] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   1, 1, 32'h1000_0044);
    tbl[22] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   0, 0, 32'h0);
    tbl[23] = mk(2'b10, 32'h0,   32'h55,  1, 2'b10, 1, 32'h55,  0, 0, 32'h0);
    tbl[24] = mk(2'b10, 32'h0,   32'h56,  1, 2'b10, 1, 32'h56,  0, 0, 32'h0);
    tbl[25] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   1, 1, 32'h1000_0055);
    tbl[26] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   1, 1, 32'h1000_0056);
    tbl[27] = mk(2'b00, 32'h0,   32'h0,   1, 2'b00, 1, 32'h0,   0, 0, 32'h0);

    // Reset state with requests already pending.
    bus.Req_SI     = 2'b11;
    bus.Operand_DI = {32'h2, 32'h1};
    bus.Ready_SI   = 1'b1;
    #12;
    check("reset gnt",   32'(bus.Gnt_SO),     32'h0);
    check("reset valid", 32'(bus.Valid_SO),   32'h0);
    check("reset id",    32'(bus.Id_DO),      32'h0);
    check("reset en",    32'(bus.Unit_En_SO), 32'h1);
    bus.Req_SI = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 28; r++) begin
      drive(tbl[r].req, tbl[r].op0, tbl[r].op1, tbl[r].rdy);
      @(negedge clk);
      check($sformatf("row%0d gnt", r),   32'(bus.Gnt_SO),          32'(tbl[r].gnt));
      check($sformatf("row%0d en", r),    32'(bus.Unit_En_SO),      32'(tbl[r].en));
      check($sformatf("row%0d uop", r),   bus.Unit_Operand_DO,      tbl[r].uop);
      check($sformatf("row%0d valid", r), 32'(bus.Valid_SO),        32'(tbl[r].vld));
      if (tbl[r].vld) begin
        check($sformatf("row%0d id", r),  32'(bus.Id_DO),           32'(tbl[r].id));
        check($sformatf("row%0d res", r), bus.Result_DO,            tbl[r].res);
      end
    end

    // Two entries in flight, then an asynchronous reset mid-cycle.
    drive(2'b10, 32'h0, 32'h7, 1);
    @(negedge clk);
    check("flight A gnt", 32'(bus.Gnt_SO), 32'h2);
    drive(2'b01, 32'h8, 32'h0, 1);
    @(negedge clk);
    check("flight B gnt", 32'(bus.Gnt_SO), 32'h1);
    drive(2'b11, 32'h3, 32'h4, 1);
    #1;
    check("pre-reset valid", 32'(bus.Valid_SO), 32'h1);
    check("pre-reset id",    32'(bus.Id_DO),    32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst gnt",   32'(bus.Gnt_SO),   32'h0);
    check("async rst valid", 32'(bus.Valid_SO), 32'h0);
    check("async rst id",    32'(bus.Id_DO),    32'h0);
    bus.Req_SI = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, 32'h0, 32'h0, 1);
      @(negedge clk);
      check($sformatf("post-rst quiet%0d valid", c), 32'(bus.Valid_SO), 32'h0);
    end
    drive(2'b11, 32'h9, 32'hA, 1);
    @(negedge clk);
    check("post-rst ptr gnt", 32'(bus.Gnt_SO),     32'h1);
    check("post-rst uop",     bus.Unit_Operand_DO, 32'h9);
    drive(2'b00, 32'h0, 32'h0, 1);
    @(negedge clk);
    check("post-rst lat1 valid", 32'(bus.Valid_SO), 32'h0);
    drive(2'b00, 32'h0, 32'h0, 1);
    @(negedge clk);
    check("post-rst lat2 valid", 32'(bus.Valid_SO), 32'h1);
    check("post-rst lat2 id",    32'(bus.Id_DO),    32'h0);
    check("post-rst lat2 res",   bus.Result_DO,     32'h1000_0009);
    drive(2'b00, 32'h0, 32'h0, 1);
    @(negedge clk);
    check("post-rst drain valid", 32'(bus.Valid_SO), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
